// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared constants, calibration states and shift clamp for adc_aligner
package adc_align_pkg;
    localparam int SAMPLE_WIDTH = 16;
    localparam int LANES = 16;
    localparam int MAX_SHIFT = 240;
    typedef enum logic [2:0] {IDLE, WAIT_FILL, SEARCH, DONE, FAIL} cal_state_t;
    function automatic logic [7:0] clamp_shift(input logic [7:0] s);
        return (s > 8'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : s;
    endfunction
endpackage

// File: rtl/adc_aligner_peak_detect.sv
// adc_peak_detect: lowest lane whose signed sample strictly exceeds the signed threshold
module adc_peak_detect import adc_align_pkg::*; #(
    parameter int NL = LANES,
    parameter int SW = SAMPLE_WIDTH
) (
    input  logic [NL*SW-1:0] word,
    input  logic [SW-1:0]    threshold,
    output logic             hit,
    output logic [3:0]       lane
);
    always_comb begin
        hit = 1'b0;
        lane = '0;
        for (int i = NL-1; i >= 0; i--) begin
            if ($signed(word[i*SW +: SW]) > $signed(threshold)) begin
                hit = 1'b1;
                lane = 4'(i);
            end
        end
    end
endmodule

// File: rtl/adc_aligner.sv
// adc_aligner: ADC word buffer with sample-offset realignment and calibration search (option ADC_ALIGN_AUTO_APPLY_EN)
module adc_aligner #(
    parameter int NUM_STAGES = 16,
    parameter int STAGE_WIDTH = 256,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STAGE_WIDTH-1:0] adc_word_in,
    input  logic                   adc_valid_in,
    input  logic [7:0]             shift_amt_in,
    input  logic                   shift_load,
    input  logic                   cal_start,
    input  logic [15:0]            cal_threshold,
    output logic [STAGE_WIDTH-1:0] adc_word_out,
    output logic                   adc_valid_out,
    output logic [7:0]             shift_amt_out,
    output logic                   cal_busy,
    output logic                   cal_done,
    output logic                   cal_fail,
    output logic [7:0]             cal_pos
);
    import adc_align_pkg::*;
    localparam int FW = $clog2(NUM_STAGES + 1);
    localparam int KW = $clog2(NUM_STAGES);
    localparam int HW = NUM_STAGES * STAGE_WIDTH;
    logic [HW-1:0] h_q, h_d;
    logic [STAGE_WIDTH-1:0] word_q, word_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0] shift_q, shift_d, pos_q, pos_d;
    logic vin_q, vin_d, vout_q, vout_d, done_q, done_d, fail_q, fail_d;
    cal_state_t state_q, state_d;
    logic full, hit;
    logic [3:0] lane;
    adc_peak_detect #(.NL(STAGE_WIDTH/SAMPLE_WIDTH), .SW(SAMPLE_WIDTH)) u_peak (
        .word(adc_word_in), .threshold(cal_threshold), .hit(hit), .lane(lane)
    );
    assign full = fill_q == FW'(NUM_STAGES);
    always_comb begin
        h_d = adc_valid_in ? {h_q[HW-STAGE_WIDTH-1:0], adc_word_in} : h_q;
        fill_d = (adc_valid_in && !full) ? fill_q + 1'b1 : fill_q;
        vin_d = adc_valid_in;
        vout_d = vin_q && full;
        word_d = h_q[shift_q*SAMPLE_WIDTH +: STAGE_WIDTH];
        state_d = state_q;
        k_d = k_q;
        done_d = done_q;
        fail_d = fail_q;
        pos_d = pos_q;
        case (state_q)
            IDLE, DONE, FAIL: if (cal_start) begin
                state_d = full ? SEARCH : WAIT_FILL;
                k_d = '0;
                done_d = 1'b0;
                fail_d = 1'b0;
                pos_d = '0;
            end
            WAIT_FILL: state_d = full ? SEARCH : WAIT_FILL;
            SEARCH: if (adc_valid_in) begin
                if (hit) begin
                    state_d = DONE;
                    done_d = 1'b1;
                    pos_d = 8'({k_q, lane});
                end else if (k_q == KW'(NUM_STAGES-1)) begin
                    state_d = FAIL;
                    fail_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        shift_d = shift_load ? clamp_shift(shift_amt_in) : shift_q;
`ifdef ADC_ALIGN_AUTO_APPLY_EN
        if (!shift_load && state_q == SEARCH && state_d == DONE) shift_d = clamp_shift(pos_d);
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            word_q <= '0;
            fill_q <= '0;
            k_q <= '0;
            shift_q <= '0;
            pos_q <= '0;
            vin_q <= 1'b0;
            vout_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            h_q <= h_d;
            word_q <= word_d;
            fill_q <= fill_d;
            k_q <= k_d;
            shift_q <= shift_d;
            pos_q <= pos_d;
            vin_q <= vin_d;
            vout_q <= vout_d;
            done_q <= done_d;
            fail_q <= fail_d;
            state_q <= state_d;
        end
    end
    assign adc_word_out = word_q;
    assign adc_valid_out = vout_q;
    assign shift_amt_out = shift_q;
    assign cal_busy = state_q == WAIT_FILL || state_q == SEARCH;
    assign cal_done = done_q;
    assign cal_fail = fail_q;
    assign cal_pos = pos_q;
endmodule

// File: tb/tb_adc_aligner.sv
// tb_adc_aligner: directed scoreboard bench for adc_aligner
module tb_adc_aligner;
    logic clk = 0, rst = 1;
    logic [255:0] adc_word_in = '0, adc_word_out;
    logic adc_valid_in = 0, shift_load = 0, cal_start = 0;
    logic [7:0] shift_amt_in = '0, shift_amt_out, cal_pos;
    logic [15:0] cal_threshold = '0;
    logic adc_valid_out, cal_busy, cal_done, cal_fail;
    int n_chk = 0, n_fail = 0;
    logic [255:0] sb[$];
    logic [255:0] m_h[16];
    int m_fill = 0, m_shift = 0, exp_shift = 0;
    logic got_valid = 0;
    always #5 clk = ~clk;
    adc_aligner dut (
        .clk(clk), .rst(rst), .adc_word_in(adc_word_in), .adc_valid_in(adc_valid_in),
        .shift_amt_in(shift_amt_in), .shift_load(shift_load), .cal_start(cal_start),
        .cal_threshold(cal_threshold), .adc_word_out(adc_word_out), .adc_valid_out(adc_valid_out),
        .shift_amt_out(shift_amt_out), .cal_busy(cal_busy), .cal_done(cal_done),
        .cal_fail(cal_fail), .cal_pos(cal_pos)
    );
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [255:0] exp_word();
        logic [255:0] e;
        for (int l = 0; l < 16; l++) begin
            int s = m_shift + l;
            e[l*16 +: 16] = m_h[s/16][(s%16)*16 +: 16];
        end
        return e;
    endfunction
    function automatic logic [255:0] idx_word(input int idx);
        logic [255:0] w;
        for (int l = 0; l < 16; l++) w[l*16 +: 16] = 16'(idx*16 + l);
        return w;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
        if (adc_valid_out) begin
            got_valid = 1;
            if (sb.size() > 0) chk("word_out", adc_word_out, sb.pop_front());
            else chk("spurious_valid", adc_valid_out, 256'(sb.size() != 0));
        end
    endtask
    task automatic send_word(input logic [255:0] w);
        bit pushed;
        for (int j = 15; j > 0; j--) m_h[j] = m_h[j-1];
        m_h[0] = w;
        if (m_fill < 16) m_fill++;
        pushed = m_fill == 16;
        if (pushed) sb.push_back(exp_word());
        adc_word_in = w;
        adc_valid_in = 1;
        got_valid = 0;
        tick();
        adc_valid_in = 0;
        tick();
        chk("valid_out", 256'(got_valid), 256'(pushed));
    endtask
    task automatic load_shift(input int v);
        shift_amt_in = 8'(v);
        shift_load = 1;
        tick();
        shift_load = 0;
        m_shift = v > 240 ? 240 : v;
        chk("shift_amt_out", 256'(shift_amt_out), 256'(m_shift));
    endtask
    task automatic pulse_start();
        cal_start = 1;
        tick();
        cal_start = 0;
    endtask
    task automatic reset_model();
        for (int j = 0; j < 16; j++) m_h[j] = '0;
        m_fill = 0;
        m_shift = 0;
        sb.delete();
    endtask
    initial begin
        logic [255:0] w;
        reset_model();
        tick();
        chk("rst_word_out", adc_word_out, '0);
        chk("rst_valid_out", 256'(adc_valid_out), '0);
        chk("rst_shift", 256'(shift_amt_out), '0);
        chk("rst_flags", 256'({cal_busy, cal_done, cal_fail}), '0);
        chk("rst_pos", 256'(cal_pos), '0);
        rst = 0;
        for (int i = 0; i < 16; i++) send_word(idx_word(i));
        load_shift(16);
        send_word(idx_word(16));
        load_shift(3);
        send_word(idx_word(17));
        load_shift(250);
        send_word(idx_word(18));
        load_shift(0);
        cal_threshold = 16'd1000;
        pulse_start();
        chk("cal_busy_search", 256'(cal_busy), 256'(1));
        send_word('0);
        send_word('0);
        w = '0;
        w[5*16 +: 16] = 16'd2000;
`ifdef ADC_ALIGN_AUTO_APPLY_EN
        m_shift = 37;
`endif
        exp_shift = m_shift;
        send_word(w);
        chk("cal_done", 256'(cal_done), 256'(1));
        chk("cal_pos_37", 256'(cal_pos), 256'(37));
        chk("cal_busy_done", 256'(cal_busy), '0);
        chk("auto_shift", 256'(shift_amt_out), 256'(exp_shift));
        pulse_start();
        chk("restart_clear", 256'({cal_done, cal_fail, cal_pos}), '0);
        send_word('0);
        shift_amt_in = 8'd8;
        shift_load = 1;
        m_shift = 8;
        send_word(w);
        shift_load = 0;
        chk("cal_pos_21", 256'(cal_pos), 256'(21));
        chk("load_beats_auto", 256'(shift_amt_out), 256'(8));
        pulse_start();
        w = '0;
        w[0 +: 16] = 16'hFFFB;
        w[7*16 +: 16] = 16'd1000;
        for (int k = 0; k < 15; k++) begin
            cal_start = k == 3;
            send_word(w);
            cal_start = 0;
        end
        chk("no_fail_yet", 256'({cal_busy, cal_fail}), 256'(2));
        send_word(w);
        chk("cal_fail", 256'({cal_done, cal_fail}), 256'(1));
        chk("fail_pos", 256'(cal_pos), '0);
        chk("fail_shift", 256'(shift_amt_out), 256'(8));
        pulse_start();
        send_word('0);
        send_word('0);
        rst = 1;
        tick();
        rst = 0;
        reset_model();
        tick();
        chk("rst_busy", 256'(cal_busy), '0);
        chk("rst_flags2", 256'({cal_done, cal_fail, cal_pos}), '0);
        chk("rst_shift2", 256'(shift_amt_out), '0);
        chk("rst_valid2", 256'(adc_valid_out), '0);
        for (int i = 100; i < 116; i++) send_word(idx_word(i));
        chk("sb_drained", 256'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
